wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the NPC core, sitting directly upstream of the general-purpose register file. It accepts one retiring instruction at a time from the execute stage over a valid/ready handshake. For loads it waits on the memory read-response channel, then aligns and sign- or zero-extends the returned data. It issues exactly one register-file write beat per instruction, together with a one-cycle commit pulse.

## Interface
- DATA_WIDTH, 32, register/data width.
- ADDR_WIDTH, 5, register index width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  execute stage offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_rd  in  ADDR_WIDTH  destination register.
- in_wen  in  1  instruction writes rd.
- in_result  in  DATA_WIDTH  ALU result (non-load).
- in_is_load  in  1  result comes from memory.
- in_load_size  in  2  0 = byte, 1 = half, 2/3 = word.
- in_load_unsigned  in  1  zero-extend instead of sign-extend.
- in_addr_lo  in  2  load address bits [1:0].
- mem_rvalid  in  1  read response valid.
- mem_rready  out  1  stage accepts read response.
- mem_rdata  in  DATA_WIDTH  raw word-aligned read data.
- mem_rresp  in  2  0 = OK; any other value = error.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- rf_waddr  out  ADDR_WIDTH  register-file write index.
- rf_wen  out  1  register-file write enable.
- rf_valid  out  1  register-file write qualifier (one cycle per instruction).
- commit  out  1  instruction retired (one-cycle pulse).
- load_fault  out  1  retiring load had an error response (pulse, aligned with commit).

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch rd, wen, result, load controls and addr_lo.
  - Go to WAIT_MEM if in_is_load, else go to WRITE.
- WAIT_MEM:
  - in_ready = 0, mem_rready = 1.
  - On mem_rvalid, compute aligned data into the result register, latch fault = (mem_rresp != 0), and go to WRITE.
- WRITE:
  - rf_valid = 1 and commit = 1 for exactly this cycle.
  - rf_wen = wen & (rd != 0) & ~fault.
  - load_fault = fault.
  - in_ready = 1. If in_valid, accept the next instruction and go to WAIT_MEM or WRITE per its in_is_load; otherwise go to IDLE.
- Load alignment:
  - Byte: mem_rdata[8*addr_lo +: 8].
  - Half: mem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - Word: mem_rdata unmodified.
  - Extension to DATA_WIDTH uses the MSB of the selected field when in_load_unsigned = 0; otherwise zero-extend.
- rf_wdata and rf_waddr are driven from the latched registers and stay stable through the WRITE cycle. Outside WRITE, rf_wen, rf_valid, commit and load_fault are 0.
- A writeback to rd = 0 still commits, but rf_wen = 0.
- mem_rvalid outside WAIT_MEM is ignored; mem_rready = 0 there.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; the in-flight instruction is dropped.
  - All outputs are 0 except in_ready, which is 1 once in IDLE.
  - All latched registers are 0.

## Timing
- Non-load: accepted on edge N, WRITE is the cycle after N, writeback lands in the register file on edge N+1. Latency is 1 cycle, throughput 1 instruction/cycle when in_valid is held.
- Load: accepted on edge N, WAIT_MEM for at least 1 cycle. With mem_rvalid sampled on edge M, WRITE is the cycle after M. Minimum latency is 2 cycles.
- Handshake transfer occurs only when in_valid & in_ready. The upstream holds its signals until the transfer; the stage never accepts in WAIT_MEM.
- Read-response transfer occurs only when mem_rvalid & mem_rready.
- Simultaneous WRITE and new in_valid: the current instruction retires and the new one is accepted on the same edge, with no bubble.

## Test plan
- ALU writeback: in_rd = 5, in_result = 0x1234_5678, in_wen = 1, is_load = 0 -> next cycle rf_valid = rf_wen = commit = 1, rf_waddr = 5, rf_wdata = 0x1234_5678.
- Signed byte load: size 0, addr_lo = 3, mem_rdata = 0x80AA_BBCC after 3 wait cycles -> mem_rready high for 3+1 cycles, then rf_wdata = 0xFFFF_FF80.
- Unsigned half load: size 1, unsigned, addr_lo = 2, mem_rdata = 0xBEEF_0001 -> rf_wdata = 0x0000_BEEF. Same case with signed -> 0xFFFF_BEEF.
- Back-to-back ALU ops to rd 1, 2, 3 with in_valid held -> commit high 3 consecutive cycles, in_ready stays 1, waddr sequence 1, 2, 3.
- Faulting load and rd = 0: load with mem_rresp = 2 -> commit = 1, load_fault = 1, rf_wen = 0. ALU op with rd = 0 -> commit = 1, rf_wen = 0.
- Reset in WAIT_MEM: deassert rst_n mid-wait -> outputs 0 immediately, in_ready = 1. A later mem_rvalid causes no writeback and no commit.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: accepts one retiring instruction, waits for load data when needed,
// aligns/extends it, and issues a single register-file write beat with a commit pulse.

module wb_load_align #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] raw,
   input  logic [1:0]            size,
   input  logic                  is_unsigned,
   input  logic [1:0]            addr_lo,
   output logic [DATA_WIDTH-1:0] aligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        byte_sgn;
   logic        half_sgn;

   always_comb begin
      byte_sel = raw[8*addr_lo +: 8];
      half_sel = raw[16*addr_lo[1] +: 16];
      byte_sgn = byte_sel[7] & ~is_unsigned;
      half_sgn = half_sel[15] & ~is_unsigned;
      case (size)
         2'd0:    aligned = {{(DATA_WIDTH-8){byte_sgn}}, byte_sel};
         2'd1:    aligned = {{(DATA_WIDTH-16){half_sgn}}, half_sel};
         default: aligned = raw;
      endcase
   end

endmodule

module wb_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_wen,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic                  in_is_load,
   input  logic [1:0]            in_load_size,
   input  logic                  in_load_unsigned,
   input  logic [1:0]            in_addr_lo,
   input  logic                  mem_rvalid,
   output logic                  mem_rready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [1:0]            mem_rresp,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic                  rf_wen,
   output logic                  rf_valid,
   output logic                  commit,
   output logic                  load_fault
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_MEM = 2'd1;
   localparam logic [1:0] S_WRITE    = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic                  wen_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [1:0]            alo_q;
   logic                  fault_q;
   logic [DATA_WIDTH-1:0] aligned;
   logic                  accept;
   logic                  rsp_take;
   logic                  in_write;

   assign in_write   = (state == S_WRITE);
   assign in_ready   = (state == S_IDLE) | in_write;
   assign mem_rready = (state == S_WAIT_MEM);
   assign accept     = in_valid & in_ready;
   assign rsp_take   = mem_rvalid & mem_rready;

   wb_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .raw         (mem_rdata),
      .size        (size_q),
      .is_unsigned (uns_q),
      .addr_lo     (alo_q),
      .aligned     (aligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         rd_q    <= '0;
         wen_q   <= 1'b0;
         res_q   <= '0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         alo_q   <= 2'd0;
         fault_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_WRITE: begin
               if (accept) begin
                  rd_q    <= in_rd;
                  wen_q   <= in_wen;
                  res_q   <= in_result;
                  size_q  <= in_load_size;
                  uns_q   <= in_load_unsigned;
                  alo_q   <= in_addr_lo;
                  fault_q <= 1'b0;
                  state   <= in_is_load ? S_WAIT_MEM : S_WRITE;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT_MEM: begin
               if (rsp_take) begin
                  res_q   <= aligned;
                  fault_q <= (mem_rresp != 2'd0);
                  state   <= S_WRITE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write data/index come straight from the latched registers so they hold for the whole beat.
   assign rf_wdata   = res_q;
   assign rf_waddr   = rd_q;
   assign rf_valid   = in_write;
   assign commit     = in_write;
   assign rf_wen     = in_write & wen_q & (rd_q != '0) & ~fault_q;
   assign load_fault = in_write & fault_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level reference model.

module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic [31:0] in_result;
   logic        in_is_load;
   logic [1:0]  in_load_size;
   logic        in_load_unsigned;
   logic [1:0]  in_addr_lo;
   logic        mem_rvalid;
   logic        mem_rready;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;
   logic [31:0] rf_wdata;
   logic [4:0]  rf_waddr;
   logic        rf_wen;
   logic        rf_valid;
   logic        commit;
   logic        load_fault;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] res;
      logic        ld;
      logic [1:0]  sz;
      logic        uns;
      logic [1:0]  alo;
      logic [31:0] raw;
      logic [1:0]  resp;
      int          waits;
   } instr_t;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
      .in_result(in_result), .in_is_load(in_is_load), .in_load_size(in_load_size),
      .in_load_unsigned(in_load_unsigned), .in_addr_lo(in_addr_lo),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
      .mem_rresp(mem_rresp), .rf_wdata(rf_wdata), .rf_waddr(rf_waddr),
      .rf_wen(rf_wen), .rf_valid(rf_valid), .commit(commit), .load_fault(load_fault)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Load result from the field-selection rules: shift, mask, then two's-complement wrap.
   function automatic logic [31:0] ref_load(input logic [31:0] raw, input int sz,
                                            input bit uns, input int alo);
      longint r = longint'(raw);
      longint v;
      int bits;
      if (sz == 0) begin
         bits = 8;
         v = (r >> (8 * alo)) & 64'hFF;
      end else if (sz == 1) begin
         bits = 16;
         v = (r >> (16 * (alo / 2))) & 64'hFFFF;
      end else begin
         return raw;
      end
      if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
      return v[31:0];
   endfunction

   task automatic drive_instr(input instr_t t);
      in_valid         = 1'b1;
      in_rd            = t.rd;
      in_wen           = t.wen;
      in_result        = t.res;
      in_is_load       = t.ld;
      in_load_size     = t.sz;
      in_load_unsigned = t.uns;
      in_addr_lo       = t.alo;
   endtask

   task automatic check_wb(input string tag, input instr_t t);
      logic [31:0] exp_data;
      bit fault;
      bit exp_wen;
      exp_data = t.ld ? ref_load(t.raw, int'(t.sz), t.uns, int'(t.alo)) : t.res;
      fault    = t.ld && (t.resp != 2'd0);
      exp_wen  = t.wen && (t.rd != 5'd0) && !fault;
      chk({tag, ".commit"},     32'(commit),     32'd1);
      chk({tag, ".rf_valid"},   32'(rf_valid),   32'd1);
      chk({tag, ".rf_wen"},     32'(rf_wen),     32'(exp_wen));
      chk({tag, ".rf_waddr"},   32'(rf_waddr),   32'(t.rd));
      chk({tag, ".rf_wdata"},   rf_wdata,        exp_data);
      chk({tag, ".load_fault"}, 32'(load_fault), 32'(fault));
   endtask

   // One isolated instruction: accept, optional memory wait, WRITE beat, then back to idle.
   task automatic run_one(input string tag, input instr_t t);
      @(negedge clk);
      drive_instr(t);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_result = $urandom();
      if (t.ld) begin
         for (int w = 0; w < t.waits; w++) begin
            chk({tag, ".rready_wait"}, 32'(mem_rready), 32'd1);
            chk({tag, ".busy"},        32'(in_ready),   32'd0);
            chk({tag, ".no_commit"},   32'(commit),     32'd0);
            @(negedge clk);
         end
         mem_rvalid = 1'b1;
         mem_rdata  = t.raw;
         mem_rresp  = t.resp;
         chk({tag, ".rready"}, 32'(mem_rready), 32'd1);
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom();
         mem_rresp  = 2'd0;
      end
      check_wb(tag, t);
      chk({tag, ".rready_wr"}, 32'(mem_rready), 32'd0);
      @(negedge clk);
      chk({tag, ".commit_clr"}, 32'(commit), 32'd0);
      chk({tag, ".wen_clr"},    32'(rf_wen), 32'd0);
   endtask

   function automatic instr_t mk(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                                 input logic ld, input logic [1:0] sz, input logic uns,
                                 input logic [1:0] alo, input logic [31:0] raw,
                                 input logic [1:0] resp, input int waits);
      instr_t t;
      t.rd = rd; t.wen = wen; t.res = res; t.ld = ld; t.sz = sz; t.uns = uns;
      t.alo = alo; t.raw = raw; t.resp = resp; t.waits = waits;
      return t;
   endfunction

   initial begin
      instr_t t;
      rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_result = '0;
      in_is_load = 1'b0; in_load_size = '0; in_load_unsigned = 1'b0; in_addr_lo = '0;
      mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
      #1;
      chk("rst.in_ready",   32'(in_ready),   32'd1);
      chk("rst.commit",     32'(commit),     32'd0);
      chk("rst.rf_valid",   32'(rf_valid),   32'd0);
      chk("rst.mem_rready", 32'(mem_rready), 32'd0);
      chk("rst.rf_wdata",   rf_wdata,        32'd0);
      chk("rst.rf_waddr",   32'(rf_waddr),   32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      run_one("alu",      mk(5'd5, 1, 32'h1234_5678, 0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 0));
      run_one("lb_s",     mk(5'd7, 1, 32'hDEAD_0000, 1, 2'd0, 0, 2'd3, 32'h80AA_BBCC, 2'd0, 3));
      run_one("lhu",      mk(5'd8, 1, 32'h0, 1, 2'd1, 1, 2'd2, 32'hBEEF_0001, 2'd0, 0));
      run_one("lh_s",     mk(5'd9, 1, 32'h0, 1, 2'd1, 0, 2'd2, 32'hBEEF_0001, 2'd0, 1));
      run_one("lh_odd",   mk(5'd10, 1, 32'h0, 1, 2'd1, 0, 2'd1, 32'h1234_8765, 2'd0, 0));
      run_one("lw",       mk(5'd11, 1, 32'h0, 1, 2'd3, 0, 2'd0, 32'hCAFE_F00D, 2'd0, 2));
      run_one("ld_fault", mk(5'd12, 1, 32'h0, 1, 2'd2, 0, 2'd0, 32'h5555_AAAA, 2'd2, 1));
      run_one("alu_r0",   mk(5'd0, 1, 32'hFFFF_FFFF, 0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 0));
      run_one("alu_nowen", mk(5'd3, 0, 32'h0000_0042, 0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 0));

      // Back-to-back ALU ops with in_valid held: one commit per cycle, no bubble.
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
         drive_instr(mk(5'(i), 1, 32'h100 + 32'(i), 0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 0));
         if (i > 1) begin
            chk("b2b.commit",   32'(commit),   32'd1);
            chk("b2b.in_ready", 32'(in_ready), 32'd1);
            chk("b2b.waddr",    32'(rf_waddr), 32'(i - 1));
            chk("b2b.wdata",    rf_wdata,      32'h100 + 32'(i - 1));
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_wb("b2b.last", mk(5'd3, 1, 32'h103, 0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 0));
      @(negedge clk);
      chk("b2b.idle", 32'(commit), 32'd0);

      // ALU op retiring while a load is accepted on the same edge.
      drive_instr(mk(5'd4, 1, 32'hAAAA_0004, 0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 0));
      @(negedge clk);
      drive_instr(mk(5'd6, 1, 32'h0, 1, 2'd0, 1, 2'd1, 32'h0, 2'd0, 0));
      check_wb("mix.alu", mk(5'd4, 1, 32'hAAAA_0004, 0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 0));
      @(negedge clk);
      in_valid = 1'b0;
      chk("mix.rready", 32'(mem_rready), 32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_9A00; mem_rresp = 2'd0;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check_wb("mix.lbu", mk(5'd6, 1, 32'h0, 1, 2'd0, 1, 2'd1, 32'h0000_9A00, 2'd0, 0));
      @(negedge clk);

      // Reset in WAIT_MEM: outputs clear at once, a late response is ignored.
      drive_instr(mk(5'd15, 1, 32'h0, 1, 2'd2, 0, 2'd0, 32'h0, 2'd0, 0));
      @(negedge clk);
      in_valid = 1'b0;
      chk("rstw.waiting", 32'(mem_rready), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstw.in_ready", 32'(in_ready),   32'd1);
      chk("rstw.rready",   32'(mem_rready), 32'd0);
      chk("rstw.commit",   32'(commit),     32'd0);
      chk("rstw.wdata",    rf_wdata,        32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF; mem_rresp = 2'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstw.no_commit", 32'(commit), 32'd0);
         chk("rstw.no_wen",    32'(rf_wen), 32'd0);
         chk("rstw.no_rready", 32'(mem_rready), 32'd0);
      end
      mem_rvalid = 1'b0;

      // Randomized transactions.
      for (int n = 0; n < 60; n++) begin
         t = mk(5'($urandom_range(0, 31)), 1'($urandom), $urandom(), 1'($urandom),
                2'($urandom), 1'($urandom), 2'($urandom), $urandom(),
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                $urandom_range(0, 4));
         run_one("rnd", t);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
